// File: rtl/nibble_toggle_sender.sv
// nibble_toggle_sender: decodes received ASCII hex digits into nibbles, queues
// them in a small FIFO and presents each one to a downstream digit shifter with
// a setup/hold handshake announced by a level toggle on shift_tgl.
// Optional feature macro: HEX_ALPHA_EN (when defined, 'A'-'F' and 'a'-'f' are
// accepted as nibbles 10-15; otherwise they are rejected).
module nibble_toggle_sender #(
  parameter int unsigned SETUP_CYCLES = 4,
  parameter int unsigned HOLD_CYCLES  = 128,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [3:0] nibble_out,
  output logic       shift_tgl,
  output logic       busy,
  output logic       overflow,
  output logic       reject
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned TMR_W = 8;

  localparam logic [CNT_W-1:0] FIFO_FULL_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic [TMR_W-1:0] SETUP_LAST    = TMR_W'(SETUP_CYCLES - 1);
  localparam logic [TMR_W-1:0] HOLD_LAST     = TMR_W'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    HOLD  = 2'd2
  } state_t;

  // FSM and datapath registers
  state_t           state;
  state_t           state_next;
  logic [TMR_W-1:0] tmr;
  logic [TMR_W-1:0] tmr_next;
  logic [3:0]       nibble_next;
  logic             tgl_next;
  logic             busy_next;
  logic             overflow_next;
  logic             reject_next;

  // FIFO storage and bookkeeping
  logic [3:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_next;
  logic [PTR_W-1:0] wr_ptr_next;
  logic [PTR_W-1:0] rd_ptr_next;

  // Decoder and handshake strobes
  logic       code_ok;
  logic [3:0] code_nib;
  logic       fifo_full;
  logic       pop;
  logic       push;
  logic       drop;

  // ASCII to nibble decode; code_ok marks a character we can queue
  always_comb begin
    code_ok  = 1'b0;
    code_nib = 4'd0;
    if (rx_data >= 8'h30 && rx_data <= 8'h39) begin
      code_ok  = 1'b1;
      code_nib = 4'(rx_data - 8'h30);
    end
`ifdef HEX_ALPHA_EN
    else if (rx_data >= 8'h41 && rx_data <= 8'h46) begin
      code_ok  = 1'b1;
      code_nib = 4'(rx_data - 8'h37);
    end
    else if (rx_data >= 8'h61 && rx_data <= 8'h66) begin
      code_ok  = 1'b1;
      code_nib = 4'(rx_data - 8'h57);
    end
`else
    // letters are left invalid, so they fall through to reject
`endif
  end

  // FIFO push/pop arbitration; a same-cycle pop frees the slot for the push
  always_comb begin
    fifo_full = (count == FIFO_FULL_CNT);
    pop       = (state == IDLE) && (count != '0);
    push      = rx_valid && code_ok && (!fifo_full || pop);
    drop      = rx_valid && code_ok && fifo_full && !pop;

    wr_ptr_next = push ? (wr_ptr + PTR_W'(1)) : wr_ptr;
    rd_ptr_next = pop  ? (rd_ptr + PTR_W'(1)) : rd_ptr;

    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + CNT_W'(1);
      2'b01:   count_next = count - CNT_W'(1);
      default: count_next = count;
    endcase
  end

  // Next-state and output logic for the setup/hold handshake
  always_comb begin
    state_next  = state;
    tmr_next    = tmr;
    nibble_next = nibble_out;
    tgl_next    = shift_tgl;

    case (state)
      IDLE: begin
        if (count != '0) begin
          nibble_next = mem[rd_ptr];
          tmr_next    = '0;
          state_next  = SETUP;
        end
      end
      SETUP: begin
        if (tmr == SETUP_LAST) begin
          tgl_next   = ~shift_tgl;
          tmr_next   = '0;
          state_next = HOLD;
        end else begin
          tmr_next = tmr + TMR_W'(1);
        end
      end
      HOLD: begin
        if (tmr == HOLD_LAST) begin
          tmr_next   = '0;
          state_next = IDLE;
        end else begin
          tmr_next = tmr + TMR_W'(1);
        end
      end
      default: begin
        tmr_next   = '0;
        state_next = IDLE;
      end
    endcase

    reject_next   = rx_valid && !code_ok;
    overflow_next = overflow || drop;
    busy_next     = (state_next != IDLE) || (count_next != '0);
  end

  // FIFO storage write; contents need no reset since count gates reads
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= code_nib;
    end
  end

  // State, FIFO bookkeeping and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      tmr        <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      nibble_out <= 4'd0;
      shift_tgl  <= 1'b0;
      busy       <= 1'b0;
      overflow   <= 1'b0;
      reject     <= 1'b0;
    end else begin
      state      <= state_next;
      tmr        <= tmr_next;
      wr_ptr     <= wr_ptr_next;
      rd_ptr     <= rd_ptr_next;
      count      <= count_next;
      nibble_out <= nibble_next;
      shift_tgl  <= tgl_next;
      busy       <= busy_next;
      overflow   <= overflow_next;
      reject     <= reject_next;
    end
  end

endmodule

// File: tb/tb_nibble_toggle_sender.sv
// Testbench for nibble_toggle_sender: directed steps with a scoreboard of
// expected nibbles, compared each time shift_tgl changes level.
module tb_nibble_toggle_sender;

  logic       clk;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [3:0] nibble_out;
  logic       shift_tgl;
  logic       busy;
  logic       overflow;
  logic       reject;

  nibble_toggle_sender #(
    .SETUP_CYCLES(4),
    .HOLD_CYCLES (128),
    .FIFO_DEPTH  (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .nibble_out(nibble_out),
    .shift_tgl (shift_tgl),
    .busy      (busy),
    .overflow  (overflow),
    .reject    (reject)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         n_checks;
  int         n_errors;
  int         cyc;
  int         tgl_count;
  int         last_tgl_cyc;
  logic       prev_tgl;
  logic [3:0] exp_q[$];

`ifdef HEX_ALPHA_EN
  localparam int ALPHA_TOGGLES = 1;
`else
  localparam int ALPHA_TOGGLES = 0;
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock; sample 1ns after the edge and score any toggle
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (!rst && shift_tgl !== prev_tgl) begin
      tgl_count++;
      last_tgl_cyc = cyc;
      check("tgl_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) check("nibble", 32'(nibble_out), 32'(exp_q.pop_front()));
    end
    prev_tgl = shift_tgl;
  endtask

  task automatic wait_toggle(input int limit, output int at);
    int start;
    start = tgl_count;
    for (int i = 0; i < limit; i++) begin
      step();
      if (tgl_count != start) break;
    end
    check("toggle_timeout", 32'(tgl_count != start), 32'd1);
    at = last_tgl_cyc;
  endtask

  task automatic wait_idle(input int limit);
    for (int i = 0; i < limit; i++) begin
      if (busy === 1'b0) break;
      step();
    end
    check("idle_timeout", 32'(busy), 32'd0);
  endtask

  task automatic send(input logic [7:0] ch);
    rx_data  = ch;
    rx_valid = 1'b1;
    step();
    rx_valid = 1'b0;
  endtask

  initial begin
    int k0;
    int t1;
    int t2;
    int start;

    n_checks = 0;
    n_errors = 0;
    cyc = 0;
    tgl_count = 0;
    last_tgl_cyc = 0;
    prev_tgl = 1'b0;
    rst = 1'b1;
    rx_valid = 1'b0;
    rx_data = 8'h00;

    // Reset held for three cycles
    for (int i = 0; i < 3; i++) step();
    check("rst_nibble", 32'(nibble_out), 32'd0);
    check("rst_tgl", 32'(shift_tgl), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_reject", 32'(reject), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    step();

    // Single '7': latency and busy window
    exp_q.push_back(4'd7);
    send(8'h37);
    k0 = cyc;
    check("single_busy_set", 32'(busy), 32'd1);
    step();
    check("single_nibble_k1", 32'(nibble_out), 32'd7);
    check("single_tgl_k1", 32'(shift_tgl), 32'd0);
    wait_toggle(20, t1);
    check("single_tgl_latency", 32'(t1 - k0), 32'd5);
    check("single_tgl_level", 32'(shift_tgl), 32'd1);
    while (cyc < k0 + 132) step();
    check("single_busy_k132", 32'(busy), 32'd1);
    step();
    step();
    check("single_busy_k134", 32'(busy), 32'd0);

    // '1' then '2' back to back: toggle spacing
    exp_q.push_back(4'd1);
    send(8'h31);
    exp_q.push_back(4'd2);
    send(8'h32);
    wait_toggle(200, t1);
    wait_toggle(200, t2);
    check("b2b_spacing", 32'(t2 - t1), 32'd133);
    wait_idle(400);

    // Six characters into a depth-4 FIFO: sixth is dropped
    start = tgl_count;
    check("ovf_before", 32'(overflow), 32'd0);
    for (int i = 0; i < 6; i++) begin
      if (i < 5) exp_q.push_back(4'(i + 1));
      send(8'(8'h31 + i));
    end
    check("ovf_set", 32'(overflow), 32'd1);
    wait_idle(1000);
    check("ovf_toggles", 32'(tgl_count - start), 32'd5);
    check("ovf_queue_drained", 32'(exp_q.size()), 32'd0);
    check("ovf_sticky", 32'(overflow), 32'd1);

    // Invalid 'G' then lowercase 'a'
    start = tgl_count;
    send(8'h47);
    check("reject_g_pulse", 32'(reject), 32'd1);
    check("reject_g_busy", 32'(busy), 32'd0);
    step();
    check("reject_g_clear", 32'(reject), 32'd0);
`ifdef HEX_ALPHA_EN
    exp_q.push_back(4'hA);
`endif
    send(8'h61);
    check("alpha_reject", 32'(reject), 32'(1 - ALPHA_TOGGLES));
    step();
    check("alpha_reject_clear", 32'(reject), 32'd0);
    wait_idle(400);
    check("alpha_toggles", 32'(tgl_count - start), 32'(ALPHA_TOGGLES));

    // Reset mid-HOLD with two nibbles queued
    exp_q.push_back(4'd8);
    send(8'h38);
    exp_q.push_back(4'd9);
    send(8'h39);
    exp_q.push_back(4'd3);
    send(8'h33);
    wait_toggle(50, t1);
    for (int i = 0; i < 10; i++) step();
    check("midhold_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_q.delete();
    check("abort_nibble", 32'(nibble_out), 32'd0);
    check("abort_tgl", 32'(shift_tgl), 32'd0);
    check("abort_overflow", 32'(overflow), 32'd0);
    check("abort_reject", 32'(reject), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    start = tgl_count;
    for (int i = 0; i < 300; i++) step();
    check("abort_no_toggle", 32'(tgl_count - start), 32'd0);
    check("abort_still_idle", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/nibble_toggle_sender.md
NIBBLE_TOGGLE_SENDER -- requirements
Module: nibble_toggle_sender

Interface
REQ-001 SHALL have parameter SETUP_CYCLES, default 4: cycles nibble_out is stable before shift_tgl toggles (range 1..255).
REQ-002 SHALL have parameter HOLD_CYCLES, default 128: cycles after a toggle before the next nibble may be driven (range 1..255).
REQ-003 SHALL have parameter FIFO_DEPTH, default 4: nibble queue entries (power of 2, at least 2).
REQ-004 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port rx_data, input, 8: received ASCII character.
REQ-007 SHALL have port rx_valid, input, 1: one-cycle strobe qualifying rx_data.
REQ-008 SHALL have port nibble_out, output, 4: data presented to the downstream digit shifter.
REQ-009 SHALL have port shift_tgl, output, 1: toggle strobe; each level change announces one new nibble.
REQ-010 SHALL have port busy, output, 1: high while the FSM is not IDLE or the FIFO is non-empty.
REQ-011 SHALL have port overflow, output, 1: sticky; set when a valid character is dropped because the FIFO is full.
REQ-012 SHALL have port reject, output, 1: one-cycle pulse for each rx_valid carrying a non-hex character.

Function
REQ-013 SHALL decode rx_data 0x30-0x39 to nibbles 0-9; all other codes are invalid, except as extended by REQ-027.
REQ-014 SHALL, on rx_valid with a valid code and the FIFO not full, write the decoded nibble at that edge.
REQ-015 SHALL, on rx_valid with a valid code and the FIFO full, drop the nibble and set overflow; a pop in the same cycle counts as not full, so the push is accepted.
REQ-016 SHALL, on rx_valid with an invalid code, pulse reject for exactly one cycle and leave the FIFO unchanged.
REQ-017 SHALL implement FSM states IDLE, SETUP and HOLD.
REQ-018 IDLE: when the FIFO is non-empty, pop the head, register it into nibble_out, clear the counter and go to SETUP.
REQ-019 SETUP: after SETUP_CYCLES cycles in SETUP, invert shift_tgl, clear the counter and go to HOLD.
REQ-020 HOLD: after HOLD_CYCLES cycles in HOLD, go to IDLE.
REQ-021 SHALL keep nibble_out unchanged from the pop until the next pop.
REQ-022 Latency: a push at edge k into an empty FIFO with the FSM in IDLE gives nibble_out valid after edge k+1 and shift_tgl toggled at edge k+1+SETUP_CYCLES.
REQ-023 Back-to-back spacing between toggles SHALL be exactly SETUP_CYCLES+HOLD_CYCLES+1 cycles.
REQ-024 FIFO pointers SHALL wrap modulo FIFO_DEPTH; the occupancy counter SHALL never exceed FIFO_DEPTH or underflow.

Reset
REQ-025 SHALL, while rst=1 at a clock edge, set nibble_out=0, shift_tgl=0, overflow=0, reject=0, FIFO empty, counters 0 and FSM IDLE; busy SHALL then read 0.
REQ-026 Reset asserted in SETUP or HOLD SHALL abort the transfer; no further toggle occurs for any queued data.

Configuration
REQ-027 SHALL treat macro HEX_ALPHA_EN as follows: when defined, 0x41-0x46 and 0x61-0x66 decode to nibbles A-F; when undefined, those codes are invalid and pulse reject.

Verification
REQ-028 Hold rst=1 for 3 cycles -> all outputs 0 and busy=0.
REQ-029 rx_data=0x37 pulsed at edge k -> nibble_out=7 after k+1; shift_tgl 0->1 at k+5; busy=0 at k+134.
REQ-030 0x31 then 0x32 on consecutive cycles -> toggles 133 cycles apart, nibble_out 1 then 2.
REQ-031 Six valid characters on consecutive cycles with FIFO_DEPTH=4 -> sixth dropped, overflow=1, exactly five toggles.
REQ-032 0x47 -> one-cycle reject, no toggle; 0x61 -> nibble A if HEX_ALPHA_EN is defined, reject if it is undefined.
REQ-033 rst pulsed mid-HOLD with two nibbles queued -> outputs 0, FIFO empty, no toggle within the following 300 cycles.
